fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register for the 5-stage MIPS core; feeds instrD/pcplus4D to decode, where the hazard unit compares rsD/rtD.
- Owns the PC and a single-outstanding-request handshake to instruction memory.
- Obeys stallF/stallD from the hazard unit and redirects on branches resolved in D (pcsrcD).
- Inserts a bubble into D while imem has not returned data.

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage plus IF/ID pipeline register.
// Owns the fetch PC and a single-outstanding-request handshake to instruction
// memory. It honours hazard stalls, redirects on branches resolved in decode,
// and inserts bubbles into decode while instruction memory has not returned data.
//
// Ports:
//   clk, reset_n           clock and synchronous active-low reset
//   stallF, stallD         hazard-unit stalls (always driven equal)
//   pcsrcD, pcbranchD      taken branch from decode and its target
//   imem_req, imem_addr    fetch request and address (address = pcF)
//   imem_rvalid,imem_rdata fetch completion and instruction word
//   instrD, pcplus4D       IF/ID instruction (0 when bubble) and PC+4
//   validD                 IF/ID holds a real instruction
//   pcF                    current fetch PC
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic [31:0] pcF
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pending_q, pending_d;
  logic [XLEN-1:0]   buf_instr_q, buf_instr_d;
  logic [XLEN-1:0]   buf_pc4_q, buf_pc4_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic              valid_q, valid_d;

  logic              done;
  logic              redirect;
  logic [XLEN-1:0]   pc_plus4;

  // Request is live in FETCH and DROP, but never while reset is held.
  assign imem_req  = reset_n && (state_q != HOLD);
  assign imem_addr = pc_q;
  assign done      = imem_req && imem_rvalid;
  assign redirect  = pcsrcD && !stallD;
  assign pc_plus4  = pc_q + XLEN'(4);

  assign pcF      = pc_q;
  assign instrD   = instr_q;
  assign pcplus4D = pc4_q;
  assign validD   = valid_q;

  // Next-state and IF/ID update; branches follow the redirect-first priority.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pending_d   = pending_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;

    if (redirect) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
      unique case (state_q)
        FETCH: begin
          if (done) begin
            pc_d    = pcbranchD;
            state_d = FETCH;
          end else begin
            pending_d = pcbranchD;
            state_d   = DROP;
          end
        end
        HOLD: begin
          pc_d    = pcbranchD;
          state_d = FETCH;
        end
        DROP: begin
          pending_d = pcbranchD;
          state_d   = DROP;
        end
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        DROP: begin
          // The discarded word must never be presented as valid.
          if (done || !stallD) begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
          end
          if (done) begin
            pc_d    = pending_q;
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (done && !stallF) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else if (done) begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = pc_plus4;
            state_d     = HOLD;
          end else if (!stallD) begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stallD) begin
            instr_d = buf_instr_q;
            pc4_d   = buf_pc4_q;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      pending_q   <= '0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with an address-tagged imem model.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stallF;
  logic        stallD;
  logic        pcsrcD;
  logic [31:0] pcbranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instrD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic [31:0] pcF;

  int checks;
  int failures;

  // Instruction word tagged with its address; nonzero even at address 0.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  assign imem_rdata = word(imem_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stallF     (stallF),
    .stallD     (stallD),
    .pcsrcD     (pcsrcD),
    .pcbranchD  (pcbranchD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instrD     (instrD),
    .pcplus4D   (pcplus4D),
    .validD     (validD),
    .pcF        (pcF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0;
    pcbranchD = 32'h0; imem_rvalid = 1'b1;
    step(); step();
    checks++; if (pcF !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pcF, 32'h0); end
    checks++; if (validD !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", validD); end
    checks++; if (instrD !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instrD); end
    checks++; if (pcplus4D !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", pcplus4D); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_zero_wait();
    step();
    checks++; if (instrD !== word(32'h0) || pcplus4D !== 32'h4 || validD !== 1'b1) begin
      failures++; $display("FAIL zw_0 got=%h/%h/%b exp=%h/4/1", instrD, pcplus4D, validD, word(32'h0)); end
    step();
    checks++; if (instrD !== word(32'h4) || pcplus4D !== 32'h8 || validD !== 1'b1) begin
      failures++; $display("FAIL zw_4 got=%h/%h/%b exp=%h/8/1", instrD, pcplus4D, validD, word(32'h4)); end
    checks++; if (pcF !== 32'h8) begin failures++; $display("FAIL zw_pc got=%h exp=8", pcF); end
  endtask

  task automatic test_wait_states();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (validD !== 1'b0 || instrD !== 32'h0) begin
        failures++; $display("FAIL wait_bubble%0d got=%h/%b exp=0/0", i, instrD, validD); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
        failures++; $display("FAIL wait_addr%0d got=%b/%h exp=1/8", i, imem_req, imem_addr); end
    end
    imem_rvalid = 1'b1;
    step();
    checks++; if (instrD !== word(32'h8) || pcplus4D !== 32'hC || validD !== 1'b1) begin
      failures++; $display("FAIL wait_done got=%h/%h/%b exp=%h/c/1", instrD, pcplus4D, validD, word(32'h8)); end
    step();
    checks++; if (instrD !== word(32'hC) || pcF !== 32'h10) begin
      failures++; $display("FAIL wait_next got=%h/%h exp=%h/10", instrD, pcF, word(32'hC)); end
  endtask

  task automatic test_stall();
    stallF = 1'b1; stallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (instrD !== word(32'hC) || pcplus4D !== 32'h10 || validD !== 1'b1) begin
        failures++; $display("FAIL stall_hold%0d got=%h/%h/%b exp=%h/10/1", i, instrD, pcplus4D, validD, word(32'hC)); end
      checks++; if (imem_req !== 1'b0 || pcF !== 32'h10) begin
        failures++; $display("FAIL stall_req%0d got=%b/%h exp=0/10", i, imem_req, pcF); end
    end
    stallF = 1'b0; stallD = 1'b0;
    step();
    checks++; if (instrD !== word(32'h10) || pcplus4D !== 32'h14 || validD !== 1'b1) begin
      failures++; $display("FAIL stall_release got=%h/%h/%b exp=%h/14/1", instrD, pcplus4D, validD, word(32'h10)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      failures++; $display("FAIL stall_resume got=%b/%h exp=1/14", imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    pcsrcD = 1'b1; pcbranchD = 32'h40;
    step();
    pcsrcD = 1'b0;
    checks++; if (validD !== 1'b0 || instrD !== 32'h0 || pcF !== 32'h40) begin
      failures++; $display("FAIL redir_bubble got=%h/%b/%h exp=0/0/40", instrD, validD, pcF); end
    step();
    checks++; if (instrD !== word(32'h40) || pcplus4D !== 32'h44 || validD !== 1'b1) begin
      failures++; $display("FAIL redir_target got=%h/%h/%b exp=%h/44/1", instrD, pcplus4D, validD, word(32'h40)); end
  endtask

  task automatic test_drop();
    imem_rvalid = 1'b0; pcsrcD = 1'b1; pcbranchD = 32'h80;
    step();
    pcsrcD = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44 || validD !== 1'b0) begin
        failures++; $display("FAIL drop_hold%0d got=%b/%h/%b exp=1/44/0", i, imem_req, imem_addr, validD); end
      if (i == 0) step();
    end
    imem_rvalid = 1'b1;
    step();
    checks++; if (validD !== 1'b0 || instrD !== 32'h0) begin
      failures++; $display("FAIL drop_discard got=%h/%b exp=0/0", instrD, validD); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      failures++; $display("FAIL drop_newaddr got=%b/%h exp=1/80", imem_req, imem_addr); end
    step();
    checks++; if (instrD !== word(32'h80) || validD !== 1'b1) begin
      failures++; $display("FAIL drop_target got=%h/%b exp=%h/1", instrD, validD, word(32'h80)); end
  endtask

  task automatic test_reset_in_drop();
    imem_rvalid = 1'b0; pcsrcD = 1'b1; pcbranchD = 32'hC0;
    step();
    pcsrcD = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req_comb got=%b exp=0", imem_req); end
    step();
    checks++; if (pcF !== 32'h0 || validD !== 1'b0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL rst_drop got=%h/%b/%b exp=0/0/0", pcF, validD, imem_req); end
    reset_n = 1'b1; imem_rvalid = 1'b1;
    step();
    checks++; if (instrD !== word(32'h0) || pcF !== 32'h4 || validD !== 1'b1) begin
      failures++; $display("FAIL rst_restart got=%h/%h/%b exp=%h/4/1", instrD, pcF, validD, word(32'h0)); end
  endtask

  task automatic test_wrap();
    pcsrcD = 1'b1; pcbranchD = 32'hFFFF_FFFC;
    step();
    pcsrcD = 1'b0;
    checks++; if (pcF !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=fffffffc", pcF); end
    step();
    checks++; if (instrD !== word(32'hFFFF_FFFC) || pcplus4D !== 32'h0 || pcF !== 32'h0 || validD !== 1'b1) begin
      failures++; $display("FAIL wrap got=%h/%h/%h/%b exp=%h/0/0/1", instrD, pcplus4D, pcF, validD, word(32'hFFFF_FFFC)); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect();
    test_drop();
    test_reset_in_drop();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
